round_robin_mux_8: RTL and testbench

Eight-channel collecting multiplexer: gathers beats from eight valid/ready source channels onto one registered output channel. It is the gathering end of the channel fan-out done by the 8-way demultiplexer. Round-robin arbitration picks the source. The winning index travels with the data on OutSel, so a downstream demultiplexer can route responses back. It sits between the peripheral request sources and the shared bus/VGA write port in the RISCV_VGA design.

---
 rtl/round_robin_mux_8.sv | 105 ++++++++++
 tb/tb_round_robin_mux_8.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_mux_8.sv
// Eight-source round-robin collecting mux onto one registered output channel; a beat accepted at edge N is on MuxOut after edge N.
// Backpressure: Ready_i is only raised when the output register is empty or draining this cycle, so a full stall costs no bubble.
module round_robin_mux_8 #(
  parameter int NrOfBits = 8
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Enable,
  input  logic [NrOfBits-1:0] MuxIn_0,
  input  logic [NrOfBits-1:0] MuxIn_1,
  input  logic [NrOfBits-1:0] MuxIn_2,
  input  logic [NrOfBits-1:0] MuxIn_3,
  input  logic [NrOfBits-1:0] MuxIn_4,
  input  logic [NrOfBits-1:0] MuxIn_5,
  input  logic [NrOfBits-1:0] MuxIn_6,
  input  logic [NrOfBits-1:0] MuxIn_7,
  input  logic                Valid_0,
  input  logic                Valid_1,
  input  logic                Valid_2,
  input  logic                Valid_3,
  input  logic                Valid_4,
  input  logic                Valid_5,
  input  logic                Valid_6,
  input  logic                Valid_7,
  output logic                Ready_0,
  output logic                Ready_1,
  output logic                Ready_2,
  output logic                Ready_3,
  output logic                Ready_4,
  output logic                Ready_5,
  output logic                Ready_6,
  output logic                Ready_7,
  output logic [NrOfBits-1:0] MuxOut,
  output logic                OutValid,
  output logic [2:0]          OutSel,
  input  logic                OutReady
);

  typedef struct packed {
    logic [2:0]          sel;
    logic [NrOfBits-1:0] dat;
  } beat_t;

  logic [NrOfBits-1:0] srcData [8];
  logic [7:0]          srcValid;
  logic [7:0]          srcReady;
  logic [2:0]          last;
  logic [2:0]          grant;
  logic                anyValid;
  logic                load;
  logic                srcXfer;
  beat_t               outBeat;

  always_comb begin
    srcData[0] = MuxIn_0;
    srcData[1] = MuxIn_1;
    srcData[2] = MuxIn_2;
    srcData[3] = MuxIn_3;
    srcData[4] = MuxIn_4;
    srcData[5] = MuxIn_5;
    srcData[6] = MuxIn_6;
    srcData[7] = MuxIn_7;
  end

  assign srcValid = {Valid_7, Valid_6, Valid_5, Valid_4, Valid_3, Valid_2, Valid_1, Valid_0};

  // Search starts one past the last winner; the 8th step wraps back onto last itself.
  always_comb begin
    logic [2:0] idx;
    grant    = last;
    anyValid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!anyValid && srcValid[idx]) begin
        anyValid = 1'b1;
        grant    = idx;
      end
    end
  end

  // Reset_n gates load so no source sees Ready while reset is held.
  assign load    = Reset_n & Enable & (~OutValid | OutReady);
  assign srcXfer = load & anyValid;
  assign srcReady = srcXfer ? (8'b1 << grant) : 8'b0;

  assign {Ready_7, Ready_6, Ready_5, Ready_4, Ready_3, Ready_2, Ready_1, Ready_0} = srcReady;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      outBeat  <= '0;
      OutValid <= 1'b0;
      last     <= 3'd7;
    end else if (srcXfer) begin
      outBeat  <= '{sel: grant, dat: srcData[grant]};
      OutValid <= 1'b1;
      last     <= grant;
    end else if (OutValid && OutReady) begin
      OutValid <= 1'b0;
    end
  end

  assign MuxOut = outBeat.dat;
  assign OutSel = outBeat.sel;

endmodule

// File: tb/tb_round_robin_mux_8.sv
// Bench for round_robin_mux_8: directed scenarios plus random traffic, all checked against a cycle-level arbitration model.
module tb_round_robin_mux_8;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Reset_n;
  logic         Enable;
  logic         OutReady;
  logic [W-1:0] srcData [8];
  logic [7:0]   srcValid;
  logic [7:0]   dutReady;
  logic [W-1:0] MuxOut;
  logic         OutValid;
  logic [2:0]   OutSel;

  int nChecks = 0;
  int nFails  = 0;

  // Reference state: what the output register should hold and who won last.
  bit           mValid;
  logic [W-1:0] mData;
  int           mSel;
  int           mLast;
  int           selLog[$];
  logic [W-1:0] datLog[$];
  logic [7:0]   lastAccepted;

  always #5 Clock = ~Clock;

  round_robin_mux_8 #(.NrOfBits(W)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable),
    .MuxIn_0(srcData[0]), .MuxIn_1(srcData[1]), .MuxIn_2(srcData[2]), .MuxIn_3(srcData[3]),
    .MuxIn_4(srcData[4]), .MuxIn_5(srcData[5]), .MuxIn_6(srcData[6]), .MuxIn_7(srcData[7]),
    .Valid_0(srcValid[0]), .Valid_1(srcValid[1]), .Valid_2(srcValid[2]), .Valid_3(srcValid[3]),
    .Valid_4(srcValid[4]), .Valid_5(srcValid[5]), .Valid_6(srcValid[6]), .Valid_7(srcValid[7]),
    .Ready_0(dutReady[0]), .Ready_1(dutReady[1]), .Ready_2(dutReady[2]), .Ready_3(dutReady[3]),
    .Ready_4(dutReady[4]), .Ready_5(dutReady[5]), .Ready_6(dutReady[6]), .Ready_7(dutReady[7]),
    .MuxOut(MuxOut), .OutValid(OutValid), .OutSel(OutSel), .OutReady(OutReady)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Winner under the round-robin rule, or -1 when nothing may be granted.
  function automatic int arbPick();
    if (!Reset_n || !Enable || (mValid && !OutReady)) return -1;
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (mLast + k) % 8;
      if (srcValid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic cycle(input bit dropAccepted);
    int         g;
    logic [7:0] expRdy;
    @(negedge Clock);
    g      = arbPick();
    expRdy = (g >= 0) ? 8'(1 << g) : 8'h00;
    checkVal("ready", {24'd0, dutReady}, {24'd0, expRdy});
    checkVal("outValid", {31'd0, OutValid}, {31'd0, mValid});
    checkVal("muxOut", {24'd0, MuxOut}, {24'd0, mData});
    checkVal("outSel", {29'd0, OutSel}, 32'(mSel));
    @(posedge Clock);
    if (mValid && OutReady) begin
      selLog.push_back(mSel);
      datLog.push_back(mData);
    end
    if (g >= 0) begin
      mData  = srcData[g];
      mSel   = g;
      mValid = 1'b1;
      mLast  = g;
    end else if (mValid && OutReady) begin
      mValid = 1'b0;
    end
    lastAccepted = expRdy;
    #1;
    if (dropAccepted) srcValid = srcValid & ~expRdy;
  endtask

  task automatic modelReset();
    mValid = 1'b0;
    mData  = '0;
    mSel   = 0;
    mLast  = 7;
    selLog.delete();
    datLog.delete();
    lastAccepted = 8'h00;
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    modelReset();
    #1;
    checkVal("rst_outValid", {31'd0, OutValid}, 32'd0);
    checkVal("rst_muxOut", {24'd0, MuxOut}, 32'd0);
    checkVal("rst_outSel", {29'd0, OutSel}, 32'd0);
    @(negedge Clock);
    checkVal("rst_ready", {24'd0, dutReady}, 32'd0);
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n  = 1'b0;
    Enable   = 1'b1;
    OutReady = 1'b1;
    srcValid = 8'hFF;
    for (int i = 0; i < 8; i++) srcData[i] = W'(8'h10 + i);
    modelReset();

    // Reset with every source requesting: nothing may be accepted.
    doReset();

    // Two sources, no backpressure: 0 then 5, back to back.
    srcValid = 8'h00;
    srcData[0] = 8'h11;
    srcData[5] = 8'h55;
    srcValid = 8'b0010_0001;
    OutReady = 1'b1;
    for (int c = 0; c < 4; c++) cycle(1'b1);
    checkVal("two_src_count", 32'(selLog.size()), 32'd2);
    if (selLog.size() == 2) begin
      checkVal("two_src_sel0", 32'(selLog[0]), 32'd0);
      checkVal("two_src_dat0", {24'd0, datLog[0]}, 32'h11);
      checkVal("two_src_sel1", 32'(selLog[1]), 32'd5);
      checkVal("two_src_dat1", {24'd0, datLog[1]}, 32'h55);
    end

    // All eight sources continuously valid: strict rotation from 0.
    doReset();
    for (int i = 0; i < 8; i++) srcData[i] = W'(i);
    srcValid = 8'hFF;
    for (int c = 0; c < 11; c++) cycle(1'b0);
    checkVal("rot_count", 32'(selLog.size()), 32'd10);
    for (int i = 0; i < 10 && i < selLog.size(); i++) begin
      checkVal("rot_sel", 32'(selLog[i]), 32'(i % 8));
      checkVal("rot_dat", {24'd0, datLog[i]}, 32'(i % 8));
    end

    // Backpressure: one accept, then a held beat for four cycles.
    doReset();
    srcValid = 8'h08;
    srcData[3] = 8'hA3;
    OutReady = 1'b0;
    for (int c = 0; c < 5; c++) cycle(1'b0);
    checkVal("bp_hold_valid", {31'd0, OutValid}, 32'd1);
    checkVal("bp_hold_data", {24'd0, MuxOut}, 32'hA3);
    checkVal("bp_hold_ready", {24'd0, lastAccepted}, 32'd0);
    OutReady = 1'b1;
    cycle(1'b1);
    checkVal("bp_drain_accept", {24'd0, lastAccepted}, 32'h08);

    // Enable low: the held beat still drains, source 2 waits.
    Enable   = 1'b0;
    srcData[2] = 8'h22;
    srcValid = 8'h04;
    for (int c = 0; c < 3; c++) cycle(1'b1);
    checkVal("en_off_drained", {31'd0, OutValid}, 32'd0);
    checkVal("en_off_ready", {24'd0, lastAccepted}, 32'd0);
    Enable = 1'b1;
    cycle(1'b1);
    checkVal("en_on_accept", {24'd0, lastAccepted}, 32'h04);

    // Wrap: after 6 wins, 7 outranks 1.
    doReset();
    srcValid = 8'h40;
    cycle(1'b1);
    srcValid = 8'h82;
    cycle(1'b1);
    checkVal("wrap_first", {24'd0, lastAccepted}, 32'h80);
    cycle(1'b1);
    checkVal("wrap_second", {24'd0, lastAccepted}, 32'h02);

    // Reset mid-stream clears a held beat without waiting for a clock edge.
    doReset();
    srcData[0] = 8'h5A;
    srcValid = 8'h01;
    OutReady = 1'b0;
    cycle(1'b1);
    checkVal("mid_held", {24'd0, MuxOut}, 32'h5A);
    #2;
    Reset_n = 1'b0;
    #1;
    checkVal("mid_rst_valid", {31'd0, OutValid}, 32'd0);
    checkVal("mid_rst_data", {24'd0, MuxOut}, 32'd0);
    checkVal("mid_rst_sel", {29'd0, OutSel}, 32'd0);
    modelReset();
    @(posedge Clock);
    #1;
    Reset_n  = 1'b1;
    OutReady = 1'b1;
    srcValid = 8'h48;
    cycle(1'b1);
    checkVal("mid_first_grant", {24'd0, lastAccepted}, 32'h08);

    // Random traffic; sources honour the hold-until-ready rule.
    srcValid = 8'h00;
    lastAccepted = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      Enable   = ($urandom % 8) != 0;
      OutReady = ($urandom % 4) != 0;
      for (int i = 0; i < 8; i++) begin
        if (!srcValid[i] || lastAccepted[i]) begin
          srcValid[i] = ($urandom % 2) != 0;
          srcData[i]  = W'($urandom);
        end
      end
      cycle(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
